// File: rtl/cmd_encoder.sv
// rtl/cmd_encoder.sv - keystroke-to-command encoder with mode validation and command FIFO
module cmd_encoder #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          MAX_DIGITS = 4,
    parameter logic [15:0] HACK_CODE  = 16'h0010
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          char_valid,
    input  logic [7:0]                    char_data,
    output logic                          char_ready,
    input  logic                          on_enemy,
    input  logic                          hacks_en,
    output logic                          cmd_valid,
    output logic [15:0]                   cmd_data,
    input  logic                          cmd_ready,
    output logic                          reject,
    output logic [1:0]                    reject_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]   MAXD    = CW'(MAX_DIGITS);
    localparam logic [PW:0]     DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_CHECK = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           reject_q, reject_d;
    logic [1:0]     code_q, code_d;

    logic [15:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q, count_d;

    logic           push, pop, ready_c;
    logic           is_digit, is_bs, is_esc, is_enter;
    logic           in_set, is_move, is_attack, is_hack;

    // Character classification and command-set decode of the accumulator
    always_comb begin
        is_digit  = (char_data >= 8'h30) && (char_data <= 8'h39);
        is_bs     = (char_data == 8'h08);
        is_esc    = (char_data == 8'h1B);
        is_enter  = (char_data == 8'h0D) || (char_data == 8'h0A);
        is_move   = (acc_q >= 16'd1) && (acc_q <= 16'd4);
        is_attack = (acc_q == 16'd5) || (acc_q == 16'd6);
        is_hack   = (acc_q == HACK_CODE);
        in_set    = is_move || is_attack || is_hack;
    end

    // Entry parsing, validation and push sequencing
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        reject_d = 1'b0;
        code_d   = code_q;
        push     = 1'b0;
        ready_c  = 1'b0;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                ready_c = 1'b1;
                if (char_valid) begin
                    if (is_digit) begin
                        // Extra digits only flag overflow so backspace can recover the entry
                        if (cnt_q < MAXD) begin
                            acc_d = {acc_q[11:0], char_data[3:0]};
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = S_ENTRY;
                    end else if (is_bs) begin
                        if (cnt_q != '0) begin
                            acc_d = acc_q >> 4;
                            cnt_d = cnt_q - CW'(1);
                            ovf_d = 1'b0;
                            if (cnt_q == CW'(1)) state_d = S_IDLE;
                        end
                    end else if (is_esc) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (is_enter) begin
                        if (cnt_q != '0) state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (ovf_q) begin
                    reject_d = 1'b1;
                    code_d   = 2'd3;
                end else if (!in_set) begin
                    reject_d = 1'b1;
                    code_d   = 2'd1;
                end else if ((is_move && on_enemy) || (is_attack && !on_enemy) ||
                             (is_hack && !hacks_en)) begin
                    reject_d = 1'b1;
                    code_d   = 2'd2;
                end
                if (reject_d) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                // A same-cycle pop frees the slot even when the FIFO is full
                if ((count_q < DEPTH_C) || pop) begin
                    push    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            reject_q <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            reject_q <= reject_d;
            code_q   <= code_d;
        end
    end

    // FIFO occupancy next-state
    always_comb begin
        pop     = cmd_ready && (count_q != '0);
        count_d = count_q;
        if (push && !pop) count_d = count_q + (PW + 1)'(1);
        else if (pop && !push) count_d = count_q - (PW + 1)'(1);
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until counted as occupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= acc_q;
    end

    assign char_ready  = ready_c && !rst;
    assign cmd_valid   = (count_q != '0);
    assign cmd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
    assign reject      = reject_q;
    assign reject_code = code_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// tb/tb_cmd_encoder.sv - randomized self-checking bench for cmd_encoder
module tb_cmd_encoder;

    localparam int DEPTH = 8;
    localparam int MAXD  = 4;
    localparam int HACK  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        on_enemy = 1'b0;
    logic        hacks_en = 1'b0;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready = 1'b0;
    logic        reject;
    logic [1:0]  reject_code;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int md[$];
    bit movf = 0;
    int last_code = 0;
    bit pend = 0;
    int pend_v = 0;

    cmd_encoder #(.FIFO_DEPTH(DEPTH), .MAX_DIGITS(MAXD), .HACK_CODE(16'h0010)) dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .on_enemy(on_enemy), .hacks_en(hacks_en),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .reject(reject), .reject_code(reject_code), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Entry is complete: decide the outcome from the typed digits and check the DUT's response
    task automatic evaluate();
        int v = 0;
        int code = 0;
        foreach (md[i]) v = v * 16 + md[i];
        if (movf) code = 3;
        else if (!(v inside {1, 2, 3, 4, 5, 6, HACK})) code = 1;
        else if (v <= 4 && on_enemy) code = 2;
        else if ((v == 5 || v == 6) && !on_enemy) code = 2;
        else if (v == HACK && !hacks_en) code = 2;
        md.delete();
        movf = 0;
        check("chk_busy", char_ready, 0);
        tick();
        if (code != 0) begin
            check("rej_pulse", reject, 1);
            check("rej_code", reject_code, code);
            last_code = code;
            tick();
            check("rej_end", reject, 0);
            check("rej_cnt", fifo_count, exp_q.size());
            check("rej_rdy", char_ready, 1);
        end else begin
            check("push_norej", reject, 0);
            if (exp_q.size() < DEPTH) begin
                tick();
                exp_q.push_back(v);
                check("push_cnt", fifo_count, exp_q.size());
                check("push_valid", cmd_valid, 1);
                check("push_head", cmd_data, exp_q[0]);
                check("push_rdy", char_ready, 1);
                check("code_hold", reject_code, last_code);
            end else begin
                pend = 1;
                pend_v = v;
                repeat (3) tick();
                check("stall_rdy", char_ready, 0);
                check("stall_cnt", fifo_count, DEPTH);
            end
        end
    endtask

    task automatic send_key(input logic [7:0] c);
        int w = 0;
        char_valid = 1'b1;
        char_data = c;
        while (!char_ready && w < 50) begin
            tick();
            w++;
        end
        if (!char_ready) check("rdy_timeout", char_ready, 1);
        tick();
        char_valid = 1'b0;
        char_data = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            if (md.size() < MAXD) md.push_back(int'(c) - 48);
            else movf = 1;
        end else if (c == 8'h08) begin
            if (md.size() > 0) begin
                void'(md.pop_back());
                movf = 0;
            end
        end else if (c == 8'h1B) begin
            md.delete();
            movf = 0;
        end else if (c == 8'h0D || c == 8'h0A) begin
            if (md.size() > 0) evaluate();
            else begin
                check("enter_ign_rdy", char_ready, 1);
                tick();
                check("enter_ign_rej", reject, 0);
                check("enter_ign_cnt", fifo_count, exp_q.size());
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check("d_valid", cmd_valid, 1);
            check("d_data", cmd_data, exp_q[0]);
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            void'(exp_q.pop_front());
            check("d_cnt", fifo_count, exp_q.size());
            if ($urandom_range(0, 1) == 1) tick();
        end
        check("empty_valid", cmd_valid, 0);
        check("empty_data", cmd_data, 0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pop_empty", fifo_count, 0);
    endtask

    task automatic fill_full();
        on_enemy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_key(8'(8'h31 + (i % 4)));
            send_key(8'h0D);
        end
        check("full_cnt", fifo_count, DEPTH);
    endtask

    task automatic random_entry();
        int kind;
        int n;
        int r;
        int v;
        kind = $urandom_range(0, 9);
        on_enemy = 1'($urandom_range(0, 1));
        hacks_en = 1'($urandom_range(0, 1));
        if (kind < 5) begin
            v = $urandom_range(1, 7);
            if (v == 7) begin
                send_key(8'h31);
                send_key(8'h30);
            end else begin
                send_key(8'(8'h30 + v));
            end
        end else begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                if (r < 14) send_key(8'(8'h30 + $urandom_range(0, 9)));
                else if (r < 17) send_key(8'h08);
                else if (r < 18) send_key(8'h1B);
                else send_key(8'h78);
            end
        end
        send_key(kind[0] ? 8'h0D : 8'h0A);
    endtask

    initial begin
        tick();
        check("rst_rdy", char_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_valid", cmd_valid, 0);
        check("rst_data", cmd_data, 0);
        check("rst_rej", reject, 0);
        check("rst_code", reject_code, 0);
        check("rst_cnt", fifo_count, 0);
        check("idle_rdy", char_ready, 1);

        on_enemy = 0; hacks_en = 0;
        send_key(8'h33); send_key(8'h0D);
        drain();
        hacks_en = 1;
        send_key(8'h31); send_key(8'h30); send_key(8'h0D);
        hacks_en = 0;
        send_key(8'h31); send_key(8'h30); send_key(8'h0D);
        on_enemy = 0;
        send_key(8'h35); send_key(8'h0D);
        on_enemy = 1;
        send_key(8'h35); send_key(8'h0D);
        send_key(8'h37); send_key(8'h0D);
        send_key(8'h31); send_key(8'h32); send_key(8'h33); send_key(8'h34); send_key(8'h35);
        send_key(8'h0D);
        on_enemy = 0;
        send_key(8'h34); send_key(8'h39); send_key(8'h08); send_key(8'h0D);
        send_key(8'h32); send_key(8'h1B); send_key(8'h0D);
        drain();

        fill_full();
        send_key(8'h32); send_key(8'h0D);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(pend_v);
        pend = 0;
        check("bp_cnt", fifo_count, DEPTH);
        check("bp_head", cmd_data, exp_q[0]);
        check("bp_rdy", char_ready, 1);
        drain();

        send_key(8'h39); send_key(8'h0D);
        send_key(8'h31); send_key(8'h32);
        rst = 1'b1;
        tick();
        check("rstE_rdy", char_ready, 0);
        check("rstE_rej", reject, 0);
        check("rstE_code", reject_code, 0);
        rst = 1'b0;
        md.delete(); movf = 0; last_code = 0;
        tick();
        check("rstE_idle", char_ready, 1);
        send_key(8'h33); send_key(8'h0D);
        drain();

        fill_full();
        send_key(8'h31); send_key(8'h0D);
        rst = 1'b1;
        tick();
        check("rstP_cnt", fifo_count, 0);
        check("rstP_valid", cmd_valid, 0);
        check("rstP_data", cmd_data, 0);
        check("rstP_rej", reject, 0);
        check("rstP_code", reject_code, 0);
        check("rstP_rdy", char_ready, 0);
        rst = 1'b0;
        exp_q.delete(); pend = 0; md.delete(); movf = 0; last_code = 0;
        tick();
        check("rstP_idle", char_ready, 1);
        check("rstP_empty", cmd_valid, 0);

        for (int e = 0; e < 80; e++) begin
            if (exp_q.size() >= DEPTH - 1 || $urandom_range(0, 7) == 0) drain();
            random_entry();
        end
        if (md.size() > 0) send_key(8'h1B);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
